// File: rtl/jt49_pkg.sv
// Shared definitions for the AY-3-8910 BDIR/BC1 bus master: FSM states and bus codes.
// Build option JT49_BUSMST_READ_EN adds the read bit to each queued request.
package jt49_pkg;

  typedef enum logic [2:0] {IDLE, ADDR, GAP1, WR, RD, GAP2} state_t;

  localparam logic [1:0] BUS_INACT = 2'b00;
  localparam logic [1:0] BUS_READ  = 2'b01;
  localparam logic [1:0] BUS_WRITE = 2'b10;
  localparam logic [1:0] BUS_LATCH = 2'b11;

`ifdef JT49_BUSMST_READ_EN
  localparam int unsigned REQ_W = 17;
`else
  localparam int unsigned REQ_W = 16;
`endif

endpackage

// File: rtl/jt49_bus_master_fifo.sv
// Synchronous request FIFO; full/empty derive from a registered occupancy count.
module jt49_bus_master_fifo #(
  parameter int unsigned FIFO_AW = 2,
  parameter int unsigned DW      = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;

  logic [DW-1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               do_push, do_pop;

  assign full    = (count == (FIFO_AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/jt49_bus_master.sv
// CPU-side BDIR/BC1 initiator for AY-3-8910 style PSGs: queued writes (and reads when
// JT49_BUSMST_READ_EN is defined) sequenced as latch, gap, data phase, gap.
module jt49_bus_master
  import jt49_pkg::*;
#(
  parameter int unsigned PHASE_CYC = 2,
  parameter int unsigned FIFO_AW   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rd,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       bdir,
  output logic       bc1,
  output logic [7:0] bus_dout,
  output logic       bus_oe,
  input  logic [7:0] bus_din
);

  state_t           state;
  logic [3:0]       pc;
  logic             pc_last;
  logic             full, empty, push, pop;
  logic [REQ_W-1:0] fifo_din, fifo_dout;
  logic [7:0]       cur_data;

  assign req_ready = ~full & ~rst;
  assign push      = req_valid & req_ready;
  assign pop       = (state == IDLE) & cen & ~empty;
  assign pc_last   = (pc == 4'(PHASE_CYC - 1));
  assign busy      = ~empty | (state != IDLE);

`ifdef JT49_BUSMST_READ_EN
  logic cur_rd;
  assign fifo_din = {req_rd, req_addr, req_data};
`else
  logic unused_inputs;
  assign fifo_din      = {req_addr, req_data};
  assign unused_inputs = ^{req_rd, bus_din};
  assign rsp_valid     = 1'b0;
  assign rsp_data      = '0;
`endif

  jt49_bus_master_fifo #(
    .FIFO_AW (FIFO_AW),
    .DW      (REQ_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  // Outputs are loaded on the transition into each state, so they are valid for the whole phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      {bdir, bc1} <= BUS_INACT;
      bus_dout    <= '0;
      bus_oe      <= 1'b0;
      cur_data    <= '0;
`ifdef JT49_BUSMST_READ_EN
      cur_rd      <= 1'b0;
`endif
    end else if (cen) begin
      if (state == IDLE) begin
        if (!empty) begin
          state       <= ADDR;
          pc          <= '0;
          {bdir, bc1} <= BUS_LATCH;
          bus_oe      <= 1'b1;
          bus_dout    <= fifo_dout[15:8];
          cur_data    <= fifo_dout[7:0];
`ifdef JT49_BUSMST_READ_EN
          cur_rd      <= fifo_dout[16];
`endif
        end
      end else if (!pc_last) begin
        pc <= pc + 4'd1;
      end else begin
        pc <= '0;
        case (state)
          ADDR: begin
            state       <= GAP1;
            {bdir, bc1} <= BUS_INACT;
          end
          GAP1: begin
`ifdef JT49_BUSMST_READ_EN
            if (cur_rd) begin
              state       <= RD;
              {bdir, bc1} <= BUS_READ;
              bus_oe      <= 1'b0;
            end else begin
              state       <= WR;
              {bdir, bc1} <= BUS_WRITE;
              bus_dout    <= cur_data;
            end
`else
            state       <= WR;
            {bdir, bc1} <= BUS_WRITE;
            bus_dout    <= cur_data;
`endif
          end
          WR, RD: begin
            state       <= GAP2;
            {bdir, bc1} <= BUS_INACT;
            bus_oe      <= 1'b0;
          end
          default: begin
            state       <= IDLE;
            {bdir, bc1} <= BUS_INACT;
            bus_oe      <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef JT49_BUSMST_READ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (cen && state == RD && pc_last) begin
        rsp_valid <= 1'b1;
        rsp_data  <= bus_din;
      end
    end
  end
`endif

endmodule

// File: tb/tb_jt49_bus_master.sv
// Self-checking bench for jt49_bus_master: transaction-level model plus directed literal traces.
module tb_jt49_bus_master;

  localparam int unsigned PHASE_CYC = 2;
  localparam int unsigned FIFO_AW   = 2;
  localparam int          DEPTH     = 4;
`ifdef JT49_BUSMST_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1, cen = 1'b1, req_valid = 1'b0, req_rd = 1'b0;
  logic [7:0] req_addr = '0, req_data = '0, bus_din = '0;
  logic       req_ready, rsp_valid, busy, bdir, bc1, bus_oe;
  logic [7:0] rsp_data, bus_dout;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  jt49_bus_master #(
    .PHASE_CYC (PHASE_CYC),
    .FIFO_AW   (FIFO_AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rd    (req_rd),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .bdir      (bdir),
    .bc1       (bc1),
    .bus_dout  (bus_dout),
    .bus_oe    (bus_oe),
    .bus_din   (bus_din)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: each request becomes four phases of PHASE_CYC cen ticks.
  logic [16:0] mq[$];
  bit          m_active = 1'b0, m_rd = 1'b0;
  int          m_seg = 0, m_cnt = 0;
  logic [7:0]  m_addr = '0, m_data = '0;
  logic [1:0]  e_code = '0;
  logic        e_oe = 1'b0, e_rv = 1'b0, e_busy = 1'b0;
  logic [7:0]  e_dout = '0, e_rdata = '0;

  function automatic void apply_seg();
    case (m_seg)
      0: begin e_code = 2'b11; e_oe = 1'b1; e_dout = m_addr; end
      1: begin e_code = 2'b00; e_oe = 1'b1; end
      2: if (m_rd) begin e_code = 2'b01; e_oe = 1'b0; end
         else begin e_code = 2'b10; e_oe = 1'b1; e_dout = m_data; end
      default: begin e_code = 2'b00; e_oe = 1'b0; end
    endcase
  endfunction

  always @(posedge clk) begin
    int sz;
    logic [16:0] ent;
    sz   = mq.size();
    e_rv = 1'b0;
    if (rst) begin
      mq.delete();
      m_active = 1'b0;
      e_code = '0; e_oe = 1'b0; e_dout = '0; e_rdata = '0;
    end else begin
      if (cen) begin
        if (!m_active) begin
          if (sz > 0) begin
            ent = mq.pop_front();
            m_rd = ent[16]; m_addr = ent[15:8]; m_data = ent[7:0];
            m_active = 1'b1; m_seg = 0; m_cnt = 0;
            apply_seg();
          end
        end else begin
          m_cnt++;
          if (m_cnt == PHASE_CYC) begin
            if (m_seg == 2 && m_rd) begin e_rv = 1'b1; e_rdata = bus_din; end
            m_seg++; m_cnt = 0;
            if (m_seg == 4) begin m_active = 1'b0; e_code = 2'b00; e_oe = 1'b0; end
            else apply_seg();
          end
        end
      end
      if (req_valid && sz < DEPTH) mq.push_back({req_rd & READ_EN, req_addr, req_data});
    end
    e_busy = (mq.size() != 0) || m_active;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("bdir",      bdir,      e_code[1]);
      check("bc1",       bc1,       e_code[0]);
      check("bus_oe",    bus_oe,    e_oe);
      check("bus_dout",  bus_dout,  e_dout);
      check("rsp_valid", rsp_valid, e_rv);
      check("rsp_data",  rsp_data,  e_rdata);
      check("busy",      busy,      e_busy);
      check("req_ready", req_ready, !rst && mq.size() < DEPTH);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one request with cen=1 and capture nine cycles of bus activity.
  logic [1:0] t_code [9];
  logic       t_oe   [9];
  logic [7:0] t_dout [9];
  logic       t_rv   [9];
  task automatic run_txn(input logic rd, input logic [7:0] a, input logic [7:0] d);
    cen = 1'b1; req_valid = 1'b1; req_rd = rd; req_addr = a; req_data = d;
    cyc();
    req_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      cyc();
      @(negedge clk);
      t_code[k] = {bdir, bc1}; t_oe[k] = bus_oe; t_dout[k] = bus_dout; t_rv[k] = rsp_valid;
    end
    cyc();
  endtask

  initial begin
    logic [1:0] lit_code [9];
    logic       lit_oe   [9];
    logic [7:0] lit_dout [9];
    bit         found;

    rst = 1'b1;
    cyc();
    chk_en = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    @(negedge clk);
    check("reset_code",  {30'd0, bdir, bc1}, 32'd0);
    check("reset_oe",    bus_oe, 1'b0);
    check("reset_busy",  busy, 1'b0);
    check("reset_ready", req_ready, 1'b1);
    check("reset_dout",  bus_dout, 8'h00);
    cyc();

    // Write 0x38 to register 7
    run_txn(1'b0, 8'h07, 8'h38);
    lit_code = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
    lit_oe   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    lit_dout = '{8'h07, 8'h07, 8'h07, 8'h07, 8'h38, 8'h38, 8'h38, 8'h38, 8'h38};
    for (int k = 0; k < 9; k++) begin
      check("wr07_code", t_code[k], lit_code[k]);
      check("wr07_oe",   t_oe[k],   lit_oe[k]);
      check("wr07_dout", t_dout[k], lit_dout[k]);
    end
    check("wr07_idle_busy", busy, 1'b0);

`ifdef JT49_BUSMST_READ_EN
    run_txn(1'b0, 8'h00, 8'h5A);
    bus_din = 8'h5A;
    run_txn(1'b1, 8'h00, 8'h00);
    lit_code = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
    for (int k = 0; k < 9; k++) begin
      check("rd00_code", t_code[k], lit_code[k]);
      check("rd00_oe",   t_oe[k],   (k < 4) ? 1'b1 : 1'b0);
      check("rd00_rv",   t_rv[k],   (k == 6) ? 1'b1 : 1'b0);
    end
    check("rd00_data", rsp_data, 8'h5A);
`else
    // Read request in a write-only build is issued as a write
    run_txn(1'b1, 8'h01, 8'h12);
    lit_code = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
    for (int k = 0; k < 9; k++) begin
      check("rdoff_code", t_code[k], lit_code[k]);
      check("rdoff_rv",   t_rv[k],   1'b0);
    end
    check("rdoff_dout", t_dout[5], 8'h12);
`endif

    // Fill the FIFO with cen held low, then drain
    cen = 1'b0; req_valid = 1'b1; req_rd = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_addr = 8'(8'h10 + i); req_data = 8'(8'hA0 + i);
      if (i < 4) cyc();
    end
    check("full_ready", req_ready, 1'b0);
    check("full_busy",  busy, 1'b1);
    cen = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (req_ready) found = 1'b1;
      cyc();
    end
    check("fifth_accepted", found, 1'b1);
    req_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      cyc();
      if (!busy) found = 1'b1;
    end
    check("drain_busy_drop", found, 1'b1);

    // Reset during the write phase with further requests queued
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_addr = 8'(i); req_data = 8'(8'h55 + i);
      cyc();
    end
    req_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if ({bdir, bc1} == 2'b10) found = 1'b1;
      else cyc();
    end
    check("reach_wr", found, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("abort_code",  {30'd0, bdir, bc1}, 32'd0);
    check("abort_oe",    bus_oe, 1'b0);
    check("abort_busy",  busy, 1'b0);
    check("abort_ready", req_ready, 1'b1);
    cyc();

    // Randomized traffic: cen always on, every 3rd clk, then random
    for (int i = 0; i < 3000; i++) begin
      case (i / 1000)
        0:       cen = 1'b1;
        1:       cen = (i % 3 == 0);
        default: cen = ($urandom_range(0, 1) == 1);
      endcase
      req_valid = ($urandom_range(0, 2) == 0);
      req_rd    = $urandom_range(0, 1) == 1;
      req_addr  = 8'($urandom);
      req_data  = 8'($urandom);
      bus_din   = 8'($urandom);
      rst       = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst = 1'b0; req_valid = 1'b0; cen = 1'b1;
    for (int i = 0; i < 60; i++) cyc();
    check("final_busy", busy, 1'b0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
